// File: rtl/serial_rx_pkg.sv
// serial_rx_pkg
//   Types and elaboration-time helpers shared by the serial frame receiver
//   and its output buffer.
//   - rx_state_e : receiver FSM states
//   - cnt_width  : width of the data-bit counter for a given DATA_W
//   - frame_len  : clocks per frame (start + data + optional parity + stop)
package serial_rx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DATA,
      PARITY,
      STOP,
      BREAK
   } rx_state_e;

   // $clog2(1) is 0, so a single-bit frame still gets a 1-bit counter.
   function automatic int cnt_width(input int data_w);
      return (data_w > 1) ? $clog2(data_w) : 1;
   endfunction

   function automatic int frame_len(input int data_w, input int parity_en);
      return data_w + 2 + ((parity_en != 0) ? 1 : 0);
   endfunction

endpackage

// File: rtl/rx_out_buffer.sv
// rx_out_buffer
//   One-entry valid/ready holding register for received words. A word
//   offered while the entry is full and not being drained is dropped and
//   recorded in the sticky overrun flag.
//   Ports:
//     clk, rst           : clock, synchronous active-high reset
//     load               : a completed word is offered this cycle
//     load_data/perr     : the offered word and its parity-error flag
//     ready              : consumer accepts the held word when dvalid&&ready
//     clr                : clear the sticky overrun flag
//     dout/perr/dvalid   : held word, its parity flag, entry occupied
//     ovr                : sticky overrun flag
module rx_out_buffer #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_perr,
   input  logic              ready,
   input  logic              clr,
   output logic [DATA_W-1:0] dout,
   output logic              perr,
   output logic              dvalid,
   output logic              ovr
);

   logic accept;
   logic drop;

   assign accept = dvalid && ready;
   assign drop   = load && dvalid && !ready;

   // NOTE: sequential state is written only with non-blocking assignments so
   // every register samples the pre-edge value of every other register.
   always_ff @(posedge clk) begin
      if (rst) begin
         dout   <= '0;
         perr   <= 1'b0;
         dvalid <= 1'b0;
         ovr    <= 1'b0;
      end else begin
         // Loading into an entry that is being drained on the same edge keeps
         // dvalid high with the new word; otherwise a drain empties the entry
         // and dout/perr keep their last value.
         if (load && (!dvalid || ready)) begin
            dout   <= load_data;
            perr   <= load_perr;
            dvalid <= 1'b1;
         end else if (accept) begin
            dvalid <= 1'b0;
         end

         // A drop on the same edge as clr wins.
         if (drop)
            ovr <= 1'b1;
         else if (clr)
            ovr <= 1'b0;
      end
   end

endmodule

// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver
//   Serial-to-parallel frame receiver fed by the shift register core's SO.
//   Frame on SI, one bit per clock: start(0), D0..D(DATA_W-1) LSB-first,
//   optional even-parity bit, stop(1). Completed words go to a one-entry
//   valid/ready buffer with parity, framing and overrun status.
//   Ports:
//     C       : clock (rising edge)
//     R       : synchronous active-high reset
//     SI      : serial line, idle high
//     DOUT    : received word (bit 0 = first data bit)
//     DVALID  : DOUT/PERR hold an unaccepted word
//     DREADY  : consumer accepts when DVALID&&DREADY at an edge
//     PERR    : parity error for the word in DOUT
//     FERR    : sticky, a frame ended with a low stop bit
//     OVR     : sticky, a completed word was dropped (buffer full)
//     CLR     : clear FERR and OVR (a same-edge error event wins)
//     BUSY    : FSM not in IDLE
module serial_frame_receiver
   import serial_rx_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int PARITY_EN = 1
) (
   input  logic              C,
   input  logic              R,
   input  logic              SI,
   output logic [DATA_W-1:0] DOUT,
   output logic              DVALID,
   input  logic              DREADY,
   output logic              PERR,
   output logic              FERR,
   output logic              OVR,
   input  logic              CLR,
   output logic              BUSY
);

   localparam int               CNT_W    = cnt_width(DATA_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   rx_state_e         state;
   logic [CNT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] shift_q;
   logic              parity_bad;
   logic              busy_q;
   logic              ferr_q;
   logic              frame_done;
   logic              frame_err;
   logic              load_perr;

   assign frame_done = (state == STOP) && SI;
   assign frame_err  = (state == STOP) && !SI;
   assign load_perr  = (PARITY_EN != 0) ? parity_bad : 1'b0;

   // NOTE: the data shift register has no reset; every bit is rewritten
   // during DATA before the word can be loaded, so stale contents after a
   // reset or an abandoned frame are never observed.
   always_ff @(posedge C) begin
      if (state == DATA)
         shift_q[bit_cnt] <= SI;
   end

   always_ff @(posedge C) begin
      if (R) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         parity_bad <= 1'b0;
         busy_q     <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (!SI) begin
                  state   <= DATA;
                  bit_cnt <= '0;
                  busy_q  <= 1'b1;
               end
            end
            DATA: begin
               if (bit_cnt == LAST_BIT)
                  state <= (PARITY_EN != 0) ? PARITY : STOP;
               else
                  bit_cnt <= bit_cnt + 1'b1;
            end
            PARITY: begin
               // shift_q is complete here; even parity means the data bits
               // and the parity bit XOR to 0.
               parity_bad <= (^shift_q) ^ SI;
               state      <= STOP;
            end
            STOP: begin
               if (SI) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end else begin
                  state <= BREAK;
               end
            end
            BREAK: begin
               // A held-low line is a break, not a new start bit.
               if (SI) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase

         if (frame_err)
            ferr_q <= 1'b1;
         else if (CLR)
            ferr_q <= 1'b0;
      end
   end

   rx_out_buffer #(
      .DATA_W (DATA_W)
   ) u_out_buffer (
      .clk       (C),
      .rst       (R),
      .load      (frame_done),
      .load_data (shift_q),
      .load_perr (load_perr),
      .ready     (DREADY),
      .clr       (CLR),
      .dout      (DOUT),
      .perr      (PERR),
      .dvalid    (DVALID),
      .ovr       (OVR)
   );

   assign FERR = ferr_q;
   assign BUSY = busy_q;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// tb_serial_frame_receiver
//   Directed scenarios from the receiver's behaviour plus a randomized run
//   checked against a word-level model of the output buffer.
module tb_serial_frame_receiver;
   import serial_rx_pkg::*;

   localparam int DATA_W    = 8;
   localparam int PARITY_EN = 1;

   logic              C = 1'b0;
   logic              R;
   logic              SI;
   logic [DATA_W-1:0] DOUT;
   logic              DVALID;
   logic              DREADY;
   logic              PERR;
   logic              FERR;
   logic              OVR;
   logic              CLR;
   logic              BUSY;

   int pass_cnt  = 0;
   int total_cnt = 0;

   // word-level model state for the randomized run
   logic              m_valid;
   logic [DATA_W-1:0] m_word;
   logic              m_perr;
   logic              m_ovr;

   serial_frame_receiver #(
      .DATA_W    (DATA_W),
      .PARITY_EN (PARITY_EN)
   ) dut (
      .C      (C),
      .R      (R),
      .SI     (SI),
      .DOUT   (DOUT),
      .DVALID (DVALID),
      .DREADY (DREADY),
      .PERR   (PERR),
      .FERR   (FERR),
      .OVR    (OVR),
      .CLR    (CLR),
      .BUSY   (BUSY)
   );

   always #5 C = ~C;

   task automatic tick();
      @(posedge C);
      #1;
   endtask

   // Sends one frame; returns right after the stop-bit edge.
   task automatic send_frame(input logic [DATA_W-1:0] d, input logic par,
                             input logic stop, input logic ready_at_stop);
      SI = 1'b0;
      tick();
      for (int i = 0; i < DATA_W; i++) begin
         SI = d[i];
         tick();
      end
      if (PARITY_EN != 0) begin
         SI = par;
         tick();
      end
      if (ready_at_stop) DREADY = 1'b1;
      SI = stop;
      tick();
   endtask

   task automatic test_reset();
      logic seen;
      R = 1'b1; SI = 1'b1; DREADY = 1'b0; CLR = 1'b0;
      repeat (2) tick();
      R = 1'b0;
      total_cnt++;
      if ({DOUT, DVALID, PERR, FERR, OVR, BUSY} !== '0)
         $display("FAIL reset_outputs: got DOUT=%h DVALID=%b PERR=%b FERR=%b OVR=%b BUSY=%b, want all 0",
                  DOUT, DVALID, PERR, FERR, OVR, BUSY);
      else pass_cnt++;
      seen = 1'b0;
      repeat (20) begin
         tick();
         if (DVALID !== 1'b0 || BUSY !== 1'b0) seen = 1'b1;
      end
      total_cnt++;
      if (seen !== 1'b0) $display("FAIL idle_quiet: DVALID/BUSY rose on idle line, want 0");
      else pass_cnt++;
   endtask

   task automatic test_single();
      logic [DATA_W-1:0] d = 8'hA5;
      DREADY = 1'b1;
      send_frame(d, ^d, 1'b1, 1'b0);
      SI = 1'b1;
      total_cnt++;
      if (DVALID !== 1'b1 || DOUT !== d || PERR !== 1'b0)
         $display("FAIL single_word: got DVALID=%b DOUT=%h PERR=%b, want 1 %h 0", DVALID, DOUT, PERR, d);
      else pass_cnt++;
      total_cnt++;
      if (BUSY !== 1'b0) $display("FAIL single_busy: got %b want 0", BUSY);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (DVALID !== 1'b0) $display("FAIL single_one_cycle: DVALID got %b want 0", DVALID);
      else pass_cnt++;
   endtask

   task automatic test_errors();
      logic [DATA_W-1:0] d = 8'h3C;
      logic bad;
      DREADY = 1'b1;
      send_frame(d, ~(^d), 1'b1, 1'b0);
      total_cnt++;
      if (DVALID !== 1'b1 || DOUT !== d || PERR !== 1'b1)
         $display("FAIL parity_err: got DVALID=%b DOUT=%h PERR=%b, want 1 %h 1", DVALID, DOUT, PERR, d);
      else pass_cnt++;
      d = 8'h77;
      send_frame(d, ^d, 1'b0, 1'b0);
      total_cnt++;
      if (FERR !== 1'b1 || DVALID !== 1'b0 || BUSY !== 1'b1)
         $display("FAIL framing_err: got FERR=%b DVALID=%b BUSY=%b, want 1 0 1", FERR, DVALID, BUSY);
      else pass_cnt++;
      bad = 1'b0;
      SI = 1'b0;
      repeat (3) begin
         tick();
         if (BUSY !== 1'b1 || DVALID !== 1'b0) bad = 1'b1;
      end
      total_cnt++;
      if (bad !== 1'b0) $display("FAIL break_hold: BUSY dropped or DVALID rose while line low");
      else pass_cnt++;
      SI = 1'b1;
      tick();
      tick();
      total_cnt++;
      if (BUSY !== 1'b0 || DVALID !== 1'b0 || FERR !== 1'b1)
         $display("FAIL break_release: got BUSY=%b DVALID=%b FERR=%b, want 0 0 1", BUSY, DVALID, FERR);
      else pass_cnt++;
      CLR = 1'b1;
      tick();
      CLR = 1'b0;
      total_cnt++;
      if (FERR !== 1'b0) $display("FAIL ferr_clr: got %b want 0", FERR);
      else pass_cnt++;
   endtask

   task automatic test_overrun();
      DREADY = 1'b0;
      send_frame(8'h11, 1'b0, 1'b1, 1'b0);
      send_frame(8'h22, 1'b0, 1'b1, 1'b0);
      SI = 1'b1;
      total_cnt++;
      if (DVALID !== 1'b1 || DOUT !== 8'h11 || OVR !== 1'b1)
         $display("FAIL overrun: got DVALID=%b DOUT=%h OVR=%b, want 1 11 1", DVALID, DOUT, OVR);
      else pass_cnt++;
      CLR = 1'b1;
      tick();
      CLR = 1'b0;
      total_cnt++;
      if (OVR !== 1'b0 || DVALID !== 1'b1 || DOUT !== 8'h11)
         $display("FAIL ovr_clr: got OVR=%b DVALID=%b DOUT=%h, want 0 1 11", OVR, DVALID, DOUT);
      else pass_cnt++;
      DREADY = 1'b1;
      tick();
      total_cnt++;
      if (DVALID !== 1'b0) $display("FAIL overrun_drain: DVALID got %b want 0", DVALID);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      DREADY = 1'b0;
      send_frame(8'h11, 1'b0, 1'b1, 1'b0);
      send_frame(8'h22, 1'b0, 1'b1, 1'b1);
      SI = 1'b1;
      total_cnt++;
      if (DVALID !== 1'b1 || DOUT !== 8'h22 || OVR !== 1'b0)
         $display("FAIL accept_and_load: got DVALID=%b DOUT=%h OVR=%b, want 1 22 0", DVALID, DOUT, OVR);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (DVALID !== 1'b0) $display("FAIL accept_and_load_drain: DVALID got %b want 0", DVALID);
      else pass_cnt++;
   endtask

   task automatic test_mid_reset();
      DREADY = 1'b1;
      SI = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         SI = i[0];
         tick();
      end
      R = 1'b1;
      SI = 1'b1;
      tick();
      R = 1'b0;
      total_cnt++;
      if (BUSY !== 1'b0 || DVALID !== 1'b0)
         $display("FAIL mid_reset: got BUSY=%b DVALID=%b, want 0 0", BUSY, DVALID);
      else pass_cnt++;
      tick();
      send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
      SI = 1'b1;
      total_cnt++;
      if (DVALID !== 1'b1 || DOUT !== 8'h5A || PERR !== 1'b0)
         $display("FAIL after_reset_frame: got DVALID=%b DOUT=%h PERR=%b, want 1 5a 0", DVALID, DOUT, PERR);
      else pass_cnt++;
      tick();
   endtask

   // One clock of the randomized run: random DREADY, then the model applies
   // the buffer rules for this edge and the DUT is compared against it.
   task automatic rtick(input logic completes, input logic [DATA_W-1:0] w, input logic pe);
      DREADY = 1'($urandom_range(0, 1));
      tick();
      if (completes) begin
         if (!m_valid || DREADY) begin
            m_valid = 1'b1;
            m_word  = w;
            m_perr  = pe;
         end else begin
            m_ovr = 1'b1;
         end
      end else if (m_valid && DREADY) begin
         m_valid = 1'b0;
      end
      total_cnt++;
      if (DVALID !== m_valid) $display("FAIL rand_dvalid: got %b want %b", DVALID, m_valid);
      else pass_cnt++;
      total_cnt++;
      if (OVR !== m_ovr) $display("FAIL rand_ovr: got %b want %b", OVR, m_ovr);
      else pass_cnt++;
      if (m_valid) begin
         total_cnt++;
         if (DOUT !== m_word || PERR !== m_perr)
            $display("FAIL rand_word: got %h/%b want %h/%b", DOUT, PERR, m_word, m_perr);
         else pass_cnt++;
      end
   endtask

   task automatic test_random();
      logic [DATA_W-1:0] d;
      logic bad;
      int gap;
      R = 1'b1; SI = 1'b1; DREADY = 1'b0; CLR = 1'b0;
      tick();
      R = 1'b0;
      m_valid = 1'b0; m_word = '0; m_perr = 1'b0; m_ovr = 1'b0;
      for (int f = 0; f < 60; f++) begin
         d   = DATA_W'($urandom);
         bad = ($urandom_range(0, 3) == 0);
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) begin
            SI = 1'b1;
            rtick(1'b0, d, bad);
         end
         SI = 1'b0;
         rtick(1'b0, d, bad);
         for (int i = 0; i < DATA_W; i++) begin
            SI = d[i];
            rtick(1'b0, d, bad);
         end
         SI = (^d) ^ bad;
         rtick(1'b0, d, bad);
         SI = 1'b1;
         rtick(1'b1, d, bad);
      end
      total_cnt++;
      if (frame_len(DATA_W, PARITY_EN) != DATA_W + 3 || FERR !== 1'b0)
         $display("FAIL rand_ferr: FERR got %b want 0", FERR);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_errors();
      test_overrun();
      test_back_to_back();
      test_mid_reset();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
